// File: rtl/cpu_trace_if.sv
// Pipeline-status and trace read-port bundle for cpu_trace.
// master = pipeline/host side, slave = trace block.
interface cpu_trace_if;
  logic [31:0] pc_4a;
  logic        kill_4a;
  logic        stall_2a;
  logic        rd_en;
  logic        rd_valid;
  logic [49:0] rd_data;

  modport master (
    output pc_4a, kill_4a, stall_2a, rd_en,
    input  rd_valid, rd_data
  );

  modport slave (
    input  pc_4a, kill_4a, stall_2a, rd_en,
    output rd_valid, rd_data
  );
endinterface

// File: rtl/cpu_trace.sv
// Stage-4 instruction trace: circular capture buffer with PC trigger,
// post-trigger window and oldest-first drain port.
module cpu_trace #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  cpu_trace_if.slave            bus,
  input  logic                  arm,
  input  logic [31:0]           trig_pc,
  input  logic [DEPTH_LOG2-1:0] post_count,
  output logic [1:0]            state,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    TRIGGERED = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t                st;
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2-1:0] remaining;
  logic [15:0]           stamp;
  logic [49:0]           mem [DEPTH];
  logic                  cap;
  logic                  hit;

  assign state = st;

  always_comb begin
    cap = 1'b0;
    hit = 1'b0;
    cap = ((st == ARMED) || (st == TRIGGERED)) && !bus.stall_2a && !arm;
    hit = (st == ARMED) && (bus.pc_4a == trig_pc) && !bus.kill_4a;
  end

  // Storage has no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (cap)
      mem[wptr] <= {stamp, bus.kill_4a, 1'b0, bus.pc_4a};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st           <= IDLE;
      count        <= '0;
      wptr         <= '0;
      rptr         <= '0;
      remaining    <= '0;
      stamp        <= '0;
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
    end else begin
      stamp        <= stamp + 1'b1;
      bus.rd_valid <= 1'b0;
      if (arm) begin
        st        <= ARMED;
        count     <= '0;
        wptr      <= '0;
        rptr      <= '0;
        remaining <= '0;
      end else if (cap) begin
        wptr <= wptr + 1'b1;
        // Full buffer: drop the oldest entry by advancing the read side.
        if (count < DEPTH_CNT)
          count <= count + 1'b1;
        else
          rptr <= rptr + 1'b1;
        if (st == ARMED) begin
          if (hit) begin
            if (post_count == '0) begin
              st <= DONE;
            end else begin
              st        <= TRIGGERED;
              remaining <= post_count;
            end
          end
        end else begin
          remaining <= remaining - 1'b1;
          if (remaining == DEPTH_LOG2'(1))
            st <= DONE;
        end
      end else if ((st == DONE) && bus.rd_en && (count != '0)) begin
        bus.rd_data  <= mem[rptr];
        bus.rd_valid <= 1'b1;
        rptr         <= rptr + 1'b1;
        count        <= count - 1'b1;
      end
    end
  end

endmodule

// File: doc/cpu_trace.md
# cpu_trace

Synthesizable instruction-trace capture block that sits beside the stage-4 end of the CPU pipeline and consumes the same pipeline status that the simulation-only debug printer shows. It records one entry per non-stalled cycle into a circular buffer. It freezes after a programmable PC trigger plus a post-trigger window. A host can then drain the buffer oldest-first through a simple read port.

## Interface
- DEPTH_LOG2, 4, log2 of buffer depth (DEPTH = 16 entries).
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc_4a  in  32  stage-4 PC.
- kill_4a  in  1  stage-4 branch/kill flag.
- stall_2a  in  1  pipeline micro-stall; no capture while high.
- arm  in  1  single-cycle pulse; clears the buffer and starts capture.
- trig_pc  in  32  trigger PC compare value.
- post_count  in  DEPTH_LOG2  number of entries captured after the trigger entry.
- rd_en  in  1  pop request; honoured only in DONE.
- rd_valid  out  1  rd_data is valid this cycle.
- rd_data  out  50  entry {stamp[15:0], kill, stall_flag(=0), pc[31:0]}, bits [49:34], [33], [32], [31:0].
- state  out  2  0 IDLE, 1 ARMED, 2 TRIGGERED, 3 DONE.
- count  out  DEPTH_LOG2+1  valid entries held, 0..DEPTH.

## Operation
- Stamp: a free-running 16-bit cycle counter. It increments every cycle and wraps 0xFFFF->0.
- Capture condition (cap): state is ARMED or TRIGGERED, stall_2a=0, and arm=0.
- On cap:
  - mem[wptr] <= {stamp, kill_4a, 1'b0, pc_4a}, then wptr++ mod DEPTH.
  - If count<DEPTH, count++.
  - Else rptr++ mod DEPTH: the oldest entry is overwritten and count stays at DEPTH.
- IDLE: no capture. arm -> ARMED.
- ARMED: on a cap cycle where pc_4a==trig_pc and kill_4a=0, the trigger entry is written and then:
  - post_count==0 -> DONE;
  - otherwise -> TRIGGERED with remaining <= post_count.
- A matching PC with kill_4a=1 is recorded as an ordinary entry and does not trigger.
- TRIGGERED: each cap decrements remaining. The cap with remaining==1 -> DONE. Trigger compare is ignored in this state.
- DONE: capture frozen.
  - rd_en with count>0: rd_data <= mem[rptr], rd_valid <= 1, rptr++, count--.
  - rd_en with count==0: rd_valid <= 0 and rd_data holds its value.
- rd_en is ignored in other states.
- arm in any state, including mid-capture or mid-drain:
  - wptr, rptr, count and remaining all go to 0; state -> ARMED;
  - rd_valid <= 0; no capture that cycle.
- Reset: state=IDLE, count=0, wptr=rptr=0, remaining=0, stamp=0, rd_valid=0, rd_data=0. Memory contents are don't-care.

## Timing
- Capture has one-cycle latency: the entry, count and state reflect the cap cycle's inputs on the next edge.
- The trigger entry is written on the same edge that changes state.
- Read has one-cycle latency: rd_en in cycle N gives rd_valid/rd_data in cycle N+1.
- rd_valid is high for exactly one cycle per accepted pop. Back-to-back rd_en gives one entry per cycle.
- Priority within a cycle: rst > arm > capture/trigger > read.
- Wrap-around: wptr and rptr wrap modulo DEPTH. The full condition is determined only by count==DEPTH.
- Stall cycles consume stamp values but no entries, so stamps show gaps.

## Test plan
- Reset mid-TRIGGERED: assert rst for 1 cycle -> state=0, count=0, rd_valid=0, rd_data=0, and the next stamp captured after arm is small (restarted from 0).
- Basic trigger:
  - Stimulus: arm, trig_pc=0x100, post_count=2; pc_4a 0x0F0,0x0F4,…,0x10C one per cycle, no stall.
  - Response: state=DONE after 0x108 is captured; count=7.
  - Seven rd_en give pcs 0x0F0…0x108 in order, with stamps increasing by 1.
  - An 8th rd_en -> rd_valid=0.
- Wrap/overwrite: arm, trig_pc=0x200, post_count=0; pcs 0x100+4k for k=0..19, then 0x200 -> count=16. The first read is pc 0x114 and the last is 0x200.
- Stall and kill:
  - Stimulus: stall_2a=1 for 3 cycles mid-stream, then pc_4a=trig_pc with kill_4a=1.
  - Response: no entries during the stall and a stamp gap of 4 across it. The killed entry has bit33=1 and state stays ARMED. The next non-killed match triggers.
- Re-arm during drain: in DONE with count=5, read 2, then pulse arm -> state=ARMED, count=0, rd_valid=0 next cycle. rd_en while ARMED produces no rd_valid.
